// File: rtl/ixc_osf_pkg.sv
// ixc_osf_pkg: shared types and constants for the event-drain block
// Holds the per-slot state enum, default sizing constants and the ID-width helper.
package ixc_osf_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, QUEUED = 2'd1, CLEARING = 2'd2} slot_e;
  localparam int NSLOT_DEF = 8;
  localparam int DEPTH_DEF = 4;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ixc_osf_rr_arb.sv
// ixc_osf_rr_arb: combinational round-robin pick of one request
// Ports: req (request vector), ptr (search start index),
//        gnt (one-hot grant), idx (granted index), any (a grant exists).
module ixc_osf_rr_arb
  import ixc_osf_pkg::*;
#(
  parameter int N  = NSLOT_DEF,
  parameter int IW = id_w(NSLOT_DEF)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  int j;
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end
endmodule

// File: rtl/ixc_osf_evdrain.sv
// ixc_osf_evdrain: drains per-slot event latches through a round-robin ID FIFO to a host
// Ports: uclk/rst_n (clock, async active-low reset), ev_req (per-slot pending level),
//        ev_clr (per-slot clear level), host_vld/host_id/host_rdy (FIFO head handshake),
//        osf_tbc (work outstanding), fifo_cnt (FIFO occupancy).
// Optional: IXC_OSF_EVDRAIN_STATS_EN adds stat_pops (saturating pop count) and
//           stat_maxocc (peak occupancy).
module ixc_osf_evdrain
  import ixc_osf_pkg::*;
#(
  parameter int NSLOT = NSLOT_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int IW = id_w(NSLOT),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             uclk,
  input  logic             rst_n,
  input  logic [NSLOT-1:0] ev_req,
  output logic [NSLOT-1:0] ev_clr,
  output logic             host_vld,
  output logic [IW-1:0]    host_id,
  input  logic             host_rdy,
  output logic             osf_tbc,
  output logic [CW-1:0]    fifo_cnt
`ifdef IXC_OSF_EVDRAIN_STATS_EN
  ,
  output logic [15:0]      stat_pops,
  output logic [CW-1:0]    stat_maxocc
`endif
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  slot_e            st    [NSLOT];
  slot_e            st_nx [NSLOT];
  logic [NSLOT-1:0] cand, gnt, queued;
  logic [IW-1:0]    ptr, gnt_idx;
  logic             gnt_any, run, push, pop;
  logic [IW-1:0]    mem [DEPTH];
  logic [PW-1:0]    rd, wr;

  ixc_osf_rr_arb #(.N(NSLOT), .IW(IW)) u_arb (
    .req (cand),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  // run is low for the first edge after reset release so no grant lands on it
  assign pop      = host_vld && host_rdy;
  assign push     = run && gnt_any && (fifo_cnt != CW'(DEPTH) || pop);
  assign host_vld = fifo_cnt != '0;
  assign host_id  = host_vld ? mem[rd] : '0;
  assign osf_tbc  = host_vld || (|queued);

  always_ff @(posedge uclk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= 1'b0;
      ptr      <= '0;
      rd       <= '0;
      wr       <= '0;
      fifo_cnt <= '0;
    end else begin
      run      <= 1'b1;
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      if (push) begin
        wr  <= wr + 1'b1;
        ptr <= (gnt_idx == IW'(NSLOT - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
    end
  end

  // storage needs no reset: host_id is masked while the FIFO is empty
  always_ff @(posedge uclk) begin
    if (push) mem[wr] <= gnt_idx;
  end

  always_ff @(posedge uclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSLOT; i++) st[i] <= IDLE;
    end else begin
      for (int i = 0; i < NSLOT; i++) st[i] <= st_nx[i];
    end
  end

  // only IDLE slots compete, so a slot still being cleared can never be queued twice
  always_comb begin
    for (int i = 0; i < NSLOT; i++) begin
      st_nx[i]  = st[i];
      cand[i]   = (st[i] == IDLE) && ev_req[i];
      queued[i] = st[i] == QUEUED;
      ev_clr[i] = st[i] == CLEARING;
      if (st[i] == IDLE && push && gnt[i]) st_nx[i] = QUEUED;
      if (st[i] == QUEUED && pop && mem[rd] == IW'(i)) st_nx[i] = CLEARING;
      if (st[i] == CLEARING && !ev_req[i]) st_nx[i] = IDLE;
    end
  end

`ifdef IXC_OSF_EVDRAIN_STATS_EN
  always_ff @(posedge uclk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pops   <= '0;
      stat_maxocc <= '0;
    end else begin
      if (pop && stat_pops != 16'hFFFF) stat_pops <= stat_pops + 1'b1;
      if (fifo_cnt > stat_maxocc) stat_maxocc <= fifo_cnt;
    end
  end
`endif
endmodule

// File: tb/tb_ixc_osf_evdrain.sv
// tb_ixc_osf_evdrain: self-checking bench for ixc_osf_evdrain (NSLOT=8, DEPTH=4)
module tb_ixc_osf_evdrain;
  logic       uclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ev_req = '0;
  logic [7:0] ev_clr;
  logic       host_vld, osf_tbc;
  logic       host_rdy = 1'b0;
  logic [2:0] host_id;
  logic [2:0] fifo_cnt;
`ifdef IXC_OSF_EVDRAIN_STATS_EN
  logic [15:0] stat_pops;
  logic [2:0]  stat_maxocc;
`endif

  ixc_osf_evdrain #(.NSLOT(8), .DEPTH(4)) dut (
    .uclk     (uclk),
    .rst_n    (rst_n),
    .ev_req   (ev_req),
    .ev_clr   (ev_clr),
    .host_vld (host_vld),
    .host_id  (host_id),
    .host_rdy (host_rdy),
    .osf_tbc  (osf_tbc),
    .fifo_cnt (fifo_cnt)
`ifdef IXC_OSF_EVDRAIN_STATS_EN
    ,
    .stat_pops   (stat_pops),
    .stat_maxocc (stat_maxocc)
`endif
  );

  always #5 uclk = ~uclk;

  typedef struct {
    logic [7:0] req;
    int         n;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   sb[$];
  int   seen[8];
  int   pop_total = 0;
  int   ptr_m = 0;
  int   mode = 0;
  bit   sb_on = 1'b1;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one clock; pops are sampled mid-cycle and scored against the expected queue
  task automatic tick();
    logic p;
    int   pid;
    p   = rst_n && host_vld && host_rdy;
    pid = int'(host_id);
    @(posedge uclk);
    #1;
    if (p) begin
      pop_total++;
      seen[pid]++;
      if (sb_on) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_order: got id %0d expected no pop", pid);
        end else chk("pop_order", pid, sb.pop_front());
      end
    end
    if (mode == 1) ev_req = ev_req & ~ev_clr;
    else if (mode == 2) ev_req = ~ev_clr;
  endtask

  // all requests raised together: grants walk upward from the pointer, wrapping
  task automatic expect_rr(input logic [7:0] m);
    int last;
    last = -1;
    for (int k = 0; k < 8; k++) begin
      int j;
      j = (ptr_m + k) % 8;
      if (m[j]) begin
        sb.push_back(j);
        last = j;
      end
    end
    if (last >= 0) ptr_m = (last + 1) % 8;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || ev_req != 0 || osf_tbc || ev_clr != 0) && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, n < budget, 1);
  endtask

  task automatic clr_seen();
    for (int k = 0; k < 8; k++) seen[k] = 0;
  endtask

  task automatic chk_dups(input string name);
    int d;
    d = 0;
    for (int k = 0; k < 8; k++) if (seen[k] > 1) d++;
    chk({name, "_dups"}, d, 0);
  endtask

  initial begin
    int p0, n, bad;
    tbl[0] = '{8'hFF, 8};
    tbl[1] = '{8'h81, 2};
    tbl[2] = '{8'h24, 2};
    tbl[3] = '{8'h5A, 4};
    tbl[4] = '{8'h01, 1};
    tbl[5] = '{8'hF0, 4};
    clr_seen();

    // reset state, with an event already pending
    ev_req = 8'h04;
    tick();
    tick();
    chk("rst_vld", host_vld, 0);
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_clr", ev_clr, 0);
    chk("rst_tbc", osf_tbc, 0);
    chk("rst_id", host_id, 0);

    // first edge after release never grants; the second does
    rst_n = 1'b1;
    expect_rr(8'h04);
    tick();
    chk("release_edge1_vld", host_vld, 0);
    tick();
    chk("release_edge2_vld", host_vld, 1);
    chk("release_edge2_id", host_id, 2);
    host_rdy = 1'b1;
    tick();
    chk("release_clr", ev_clr, 8'h04);
    ev_req = 8'h00;
    tick();
    chk("release_clr_off", ev_clr, 0);

    // single event latency
    ev_req = 8'h08;
    expect_rr(8'h08);
    tick();
    chk("single_vld", host_vld, 1);
    chk("single_id", host_id, 3);
    tick();
    chk("single_clr", ev_clr, 8'h08);
    tick();
    chk("single_clr_hold", ev_clr, 8'h08);
    ev_req = 8'h00;
    tick();
    chk("single_clr_off", ev_clr, 0);
    chk("single_tbc_off", osf_tbc, 0);

    // round-robin order over a table of request patterns
    mode = 1;
    foreach (tbl[v]) begin
      clr_seen();
      p0 = pop_total;
      ev_req = tbl[v].req;
      expect_rr(tbl[v].req);
      drain("rr", 80);
      chk("rr_count", pop_total - p0, tbl[v].n);
      chk_dups("rr");
    end

    // full back-pressure then drain
    clr_seen();
    host_rdy = 1'b0;
    p0 = pop_total;
    ev_req = 8'hFF;
    expect_rr(8'hFF);
    repeat (10) tick();
    chk("bp_cnt", fifo_cnt, 4);
    chk("bp_tbc", osf_tbc, 1);
    chk("bp_vld", host_vld, 1);
    chk("bp_id", host_id, sb[0]);
    chk("bp_clr", ev_clr, 0);
    repeat (3) tick();
    chk("bp_cnt_hold", fifo_cnt, 4);
    chk("bp_id_hold", host_id, sb[0]);
`ifdef IXC_OSF_EVDRAIN_STATS_EN
    chk("stat_maxocc", stat_maxocc, 4);
`endif
    host_rdy = 1'b1;
    drain("bp", 80);
    chk("bp_count", pop_total - p0, 8);
    chk_dups("bp");

    // ev_req held long after clear starts: no second push
    mode = 0;
    ev_req = 8'h20;
    expect_rr(8'h20);
    n = 0;
    while (!ev_clr[5] && n < 10) begin
      tick();
      n++;
    end
    chk("slow_clr_seen", ev_clr[5], 1);
    bad = 0;
    repeat (20) begin
      tick();
      if (ev_clr !== 8'h20 || host_vld !== 1'b0) bad++;
    end
    chk("slow_hold", bad, 0);
    ev_req = 8'h00;
    tick();
    chk("slow_clr_off", ev_clr, 0);

    // request drops while queued: still delivered and cleared
    host_rdy = 1'b0;
    ev_req = 8'h02;
    expect_rr(8'h02);
    tick();
    ev_req = 8'h00;
    tick();
    tick();
    chk("spur_vld", host_vld, 1);
    chk("spur_id", host_id, 1);
    chk("spur_tbc", osf_tbc, 1);
    host_rdy = 1'b1;
    tick();
    chk("spur_clr", ev_clr, 8'h02);
    tick();
    chk("spur_clr_off", ev_clr, 0);

    // reset mid-stream discards the FIFO; pending events come back
    host_rdy = 1'b0;
    ev_req = 8'h07;
    repeat (4) tick();
    chk("mid_cnt", fifo_cnt, 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", host_vld, 0);
    chk("mid_rst_cnt", fifo_cnt, 0);
    chk("mid_rst_clr", ev_clr, 0);
    chk("mid_rst_tbc", osf_tbc, 0);
    chk("mid_rst_id", host_id, 0);
    sb.delete();
    ptr_m = 0;
    pop_total = 0;
    clr_seen();
    tick();
    tick();
    chk("mid_rst_clr_hold", ev_clr, 0);
    rst_n = 1'b1;
    mode = 1;
    expect_rr(8'h07);
    host_rdy = 1'b1;
    drain("mid", 60);
    chk("mid_count", pop_total, 3);
    chk_dups("mid");

`ifdef IXC_OSF_EVDRAIN_STATS_EN
    chk("stat_pops_small", stat_pops, pop_total);
    mode = 2;
    sb_on = 1'b0;
    n = 0;
    while (pop_total < 70000 && n < 90000) begin
      tick();
      n++;
    end
    chk("stat_flood_done", pop_total >= 70000, 1);
    chk("stat_pops_sat", stat_pops, 16'hFFFF);
    mode = 0;
    ev_req = 8'h00;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ixc_osf_evdrain.md
IXC_OSF_EVDRAIN -- requirements
Module: ixc_osf_evdrain

Interface
REQ-001 The block SHALL have parameter NSLOT, default 8: number of event-capture slots served.
REQ-002 The block SHALL have parameter DEPTH, default 4: event-ID FIFO depth (power of two, 2..16).
REQ-003 The block SHALL have port uclk, input, 1: sole clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port ev_req, input, NSLOT: per-slot level "event pending" from the capture latches.
REQ-006 The block SHALL have port ev_clr, output, NSLOT: per-slot level clear back to the capture latch.
REQ-007 The block SHALL have port host_vld, output, 1: FIFO head holds a valid event ID.
REQ-008 The block SHALL have port host_id, output, $clog2(NSLOT): slot index at the FIFO head.
REQ-009 The block SHALL have port host_rdy, input, 1: host accepts the head this cycle.
REQ-010 The block SHALL have port osf_tbc, output, 1: "to be called": any slot QUEUED, or host_vld.
REQ-011 The block SHALL have port fifo_cnt, output, $clog2(DEPTH)+1: current FIFO occupancy.

Function
REQ-012 Each slot SHALL run its own 3-state FSM: IDLE, QUEUED, CLEARING.
REQ-013 Candidates SHALL be the slots in IDLE with ev_req high; one candidate is granted per cycle, round-robin.
REQ-014 The round-robin pointer SHALL start at slot 0 and move to granted index + 1 (mod NSLOT) after each grant; the grant is the lowest candidate index at or after the pointer, wrapping.
REQ-015 A grant SHALL occur only when fifo_cnt < DEPTH, or when fifo_cnt == DEPTH and a pop happens in the same cycle.
REQ-016 On a grant, the slot's ID SHALL be pushed at the edge and the slot SHALL move IDLE->QUEUED.
REQ-017 A pop SHALL occur when host_vld && host_rdy; the popped slot SHALL move QUEUED->CLEARING at that edge.
REQ-018 ev_clr[i] SHALL be high exactly while slot i is in CLEARING.
REQ-019 A slot in CLEARING SHALL return to IDLE on the first edge at which ev_req[i] is low; the slot is not re-grantable before then, so no event is queued twice.
REQ-020 Latency SHALL be as follows when the FIFO is empty and ev_req[i] rises in cycle N: host_vld=1 and host_id=i in cycle N+1; a pop in N+1 gives ev_clr[i]=1 in N+2.
REQ-021 host_vld and host_id SHALL be driven from registered FIFO state only, with no combinational path from ev_req or host_rdy.
REQ-022 host_id SHALL hold stable while host_vld=1 and host_rdy=0.
REQ-023 When a push and a pop occur in the same cycle, fifo_cnt SHALL be unchanged and FIFO order SHALL be preserved.
REQ-024 If ev_req[i] drops while slot i is QUEUED, the slot SHALL stay queued; the host still receives the ID and ev_clr follows (spurious-drop tolerant).
REQ-025 osf_tbc SHALL be combinational from registered state: OR of all QUEUED flags and host_vld.

Reset
REQ-026 rst_n low SHALL asynchronously force all slots to IDLE, the pointer to 0, fifo_cnt=0, host_vld=0, host_id=0, ev_clr=0 and osf_tbc=0.
REQ-027 Reset asserted mid-operation SHALL discard queued IDs without emitting ev_clr; events still pending on ev_req SHALL be re-queued after rst_n deasserts.
REQ-028 The first grant after reset release SHALL occur on the second rising uclk edge after rst_n rises (the first edge is a synchronised-release edge).

Configuration
REQ-029 When macro IXC_OSF_EVDRAIN_STATS_EN is defined, the block SHALL add outputs stat_pops (16 bits, saturating at 0xFFFF, counts pops) and stat_maxocc ($clog2(DEPTH)+1 bits, highest fifo_cnt observed); both are cleared by reset.
REQ-030 When IXC_OSF_EVDRAIN_STATS_EN is undefined, those ports and their registers SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 Package ixc_osf_pkg SHALL hold the slot-state enum (IDLE/QUEUED/CLEARING), the default parameter constants, and the ID-width helper function.
REQ-032 The round-robin arbiter SHALL be sub-module ixc_osf_rr_arb (request vector, pointer in; one-hot grant and index out; combinational); the FIFO and slot FSMs stay in ixc_osf_evdrain.

Verification
REQ-033 The bench SHALL cover a single event: ev_req[3] high in cycle 10, host_rdy=1 -> host_vld=1, host_id=3 in cycle 11; ev_clr[3]=1 in cycle 12; ev_req[3] dropped in cycle 13 -> slot IDLE at the cycle 13 edge.
REQ-034 The bench SHALL cover round-robin order: ev_req=0xFF in one cycle, host_rdy=1 -> IDs 0,1,...,7 in order, each exactly once.
REQ-035 The bench SHALL cover full back-pressure: NSLOT=8, DEPTH=4, ev_req=0xFF, host_rdy=0 -> fifo_cnt reaches 4 and holds, 4 slots QUEUED, osf_tbc=1; raising host_rdy then drains all 8 IDs with no duplicate.
REQ-036 The bench SHALL cover the slow drop case: ev_req[5] held high for 20 cycles after ev_clr[5] rises -> no second ID 5 is pushed; ev_clr[5] stays high until ev_req[5] falls.
REQ-037 The bench SHALL cover reset mid-stream: 3 IDs queued, rst_n pulsed low -> all outputs 0 immediately; ev_req still high -> the IDs re-appear after release.
REQ-038 The bench SHALL cover statistics with IXC_OSF_EVDRAIN_STATS_EN defined: 70000 pops -> stat_pops=0xFFFF; with DEPTH=4 filled -> stat_maxocc=4.
